// File: rtl/axi_rab_pkg.sv
// Shared constants for the RAB AXI helpers: BRESP codes and the B-channel
// sender state encoding.
package axi_rab_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BWCH_IDLE  = 2'd0,
    BWCH_LOCAL = 2'd1,
    BWCH_FWD   = 2'd2
  } bwch_state_e;

endpackage

// File: rtl/axi_buffer_rab.sv
// Small show-ahead FIFO with synchronous active-low reset. It exposes the head
// and the entry behind it so a consumer can chain pops on consecutive cycles.
module axi_buffer_rab #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_next,
  output logic                  empty,
  output logic                  full,
  output logic                  multi
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer is dropped even when a pop frees a slot that cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push_ok && !pop_ok) count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop_ok) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= data_in;
  end

  assign data_out  = mem[rd_ptr_reg];
  assign data_next = mem[ptr_inc(rd_ptr_reg)];
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign multi     = (count_reg > CNT_W'(1));

endmodule

// File: rtl/axi4_bwch_sender.sv
// AXI4 B-channel sender: forwards master B responses and injects error responses
// for dropped writes. Define AXI_RAB_DROP_DECERR_EN to answer drops with DECERR.
module axi4_bwch_sender
  import axi_rab_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 2,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arst,
  input  logic                        trans_drop,
  input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  input  logic                        drop_wlast,
  output logic                        drop_full,
  output logic                        response_sent,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                  s_axi4_bresp,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_buser,
  output logic                        s_axi4_bvalid,
  input  logic                        s_axi4_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                  m_axi4_bresp,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_buser,
  input  logic                        m_axi4_bvalid,
  output logic                        m_axi4_bready
);

  localparam int WL_W = $clog2(DROP_FIFO_DEPTH) + 1;
`ifdef AXI_RAB_DROP_DECERR_EN
  localparam logic [1:0] DROP_RESP = BRESP_DECERR;
`else
  localparam logic [1:0] DROP_RESP = BRESP_SLVERR;
`endif

  bwch_state_e                 state_reg;
  logic [C_AXI_ID_WIDTH-1:0]   bid_reg;
  logic [1:0]                  bresp_reg;
  logic [C_AXI_USER_WIDTH-1:0] buser_reg;
  logic [WL_W-1:0]             wlast_cnt_reg;

  logic [C_AXI_ID_WIDTH-1:0]   fifo_head;
  logic [C_AXI_ID_WIDTH-1:0]   fifo_next;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        fifo_multi;

  logic                        bvalid;
  logic                        handshake;
  logic                        local_pop;
  logic                        choose;
  logic                        local_pend;
  logic                        fwd_take;

  assign bvalid    = (state_reg != BWCH_IDLE);
  assign handshake = bvalid & s_axi4_bready;
  assign local_pop = handshake & (state_reg == BWCH_LOCAL);
  assign choose    = (state_reg == BWCH_IDLE) | handshake;

  // When the current local response is leaving, judge the entry behind it so
  // consecutive local responses can go out back-to-back without reusing the head.
  assign local_pend = local_pop ? (fifo_multi & (wlast_cnt_reg > WL_W'(1)))
                                : (~fifo_empty & (wlast_cnt_reg != '0));
  assign fwd_take   = choose & ~local_pend & m_axi4_bvalid;

  axi_buffer_rab #(
    .DATA_WIDTH (C_AXI_ID_WIDTH),
    .DEPTH      (DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk       (axi4_aclk),
    .rstn      (~axi4_arst),
    .push      (trans_drop),
    .data_in   (trans_id),
    .pop       (local_pop),
    .data_out  (fifo_head),
    .data_next (fifo_next),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .multi     (fifo_multi)
  );

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      wlast_cnt_reg <= '0;
    end else if (drop_wlast && !local_pop) begin
      wlast_cnt_reg <= wlast_cnt_reg + 1'b1;
    end else if (!drop_wlast && local_pop) begin
      wlast_cnt_reg <= wlast_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state_reg <= BWCH_IDLE;
      bid_reg   <= '0;
      bresp_reg <= '0;
      buser_reg <= '0;
    end else if (choose) begin
      if (local_pend) begin
        state_reg <= BWCH_LOCAL;
        bid_reg   <= local_pop ? fifo_next : fifo_head;
        bresp_reg <= DROP_RESP;
        buser_reg <= '0;
      end else if (m_axi4_bvalid) begin
        state_reg <= BWCH_FWD;
        bid_reg   <= m_axi4_bid;
        bresp_reg <= m_axi4_bresp;
        buser_reg <= m_axi4_buser;
      end else begin
        state_reg <= BWCH_IDLE;
      end
    end
  end

  // Reset masks every control output immediately, before the registers clear.
  assign s_axi4_bvalid = bvalid & ~axi4_arst;
  assign s_axi4_bid    = bid_reg;
  assign s_axi4_bresp  = bresp_reg;
  assign s_axi4_buser  = buser_reg;
  assign response_sent = handshake & ~axi4_arst;
  assign m_axi4_bready = fwd_take & ~axi4_arst;
  assign drop_full     = fifo_full & ~axi4_arst;

endmodule
